// File: rtl/sim_uart_arbiter_if.sv
// Bus bundle between the per-tile wishbone masters, the message arbiter
// and the shared simulator UART slave port.
interface sim_uart_arbiter_if #(
  parameter int NUM  = 4,
  parameter int Dw   = 32,
  parameter int S_Aw = 7,
  parameter int TAGw = 3,
  parameter int SELw = 4
);
  // Master side, master k packed at [k*W +: W]
  logic [NUM*Dw-1:0]   m_dat_i;
  logic [NUM*SELw-1:0] m_sel_i;
  logic [NUM*S_Aw-1:0] m_addr_i;
  logic [NUM*TAGw-1:0] m_cti_i;
  logic [NUM-1:0]      m_stb_i;
  logic [NUM-1:0]      m_cyc_i;
  logic [NUM-1:0]      m_we_i;
  logic [Dw-1:0]       m_dat_o;
  logic [NUM-1:0]      m_ack_o;

  // UART slave side
  logic [Dw-1:0]       u_dat_o;
  logic [SELw-1:0]     u_sel_o;
  logic [S_Aw-1:0]     u_addr_o;
  logic [TAGw-1:0]     u_cti_o;
  logic                u_stb_o;
  logic                u_cyc_o;
  logic                u_we_o;
  logic [Dw-1:0]       u_dat_i;
  logic                u_ack_i;

  // One-hot current owner
  logic [NUM-1:0]      grant_o;

  // The arbiter itself
  modport slave (
    input  m_dat_i, m_sel_i, m_addr_i, m_cti_i, m_stb_i, m_cyc_i, m_we_i,
    input  u_dat_i, u_ack_i,
    output m_dat_o, m_ack_o,
    output u_dat_o, u_sel_o, u_addr_o, u_cti_o, u_stb_o, u_cyc_o, u_we_o,
    output grant_o
  );

  // Whatever drives the masters and answers as the UART
  modport master (
    output m_dat_i, m_sel_i, m_addr_i, m_cti_i, m_stb_i, m_cyc_i, m_we_i,
    output u_dat_i, u_ack_i,
    input  m_dat_o, m_ack_o,
    input  u_dat_o, u_sel_o, u_addr_o, u_cti_o, u_stb_o, u_cyc_o, u_we_o,
    input  grant_o
  );
endinterface

// File: rtl/sim_uart_arbiter.sv
// Message-granular arbiter sharing one simulator UART among NUM masters.
// Ownership is held for a whole line and released on end-of-line, a
// character limit, or an owner-idle timeout; the next owner is round-robin.
module sim_uart_arbiter #(
  parameter int         NUM          = 4,
  parameter int         Dw           = 32,
  parameter int         S_Aw         = 7,
  parameter int         TAGw         = 3,
  parameter int         SELw         = 4,
  parameter int         LOCK_TIMEOUT = 1000,
  parameter int         MAX_CHARS    = 100,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic               clk,
  input  logic               reset,
  sim_uart_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM);
  localparam int CW = $clog2(MAX_CHARS + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state;
  logic [NUM-1:0]  grant;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   char_cnt;
  logic [TW-1:0]   idle_cnt;

  logic [NUM-1:0]  req;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;

  logic [Dw-1:0]   own_dat;
  logic [SELw-1:0] own_sel;
  logic [S_Aw-1:0] own_addr;
  logic [TAGw-1:0] own_cti;
  logic            own_stb;
  logic            own_cyc;
  logic            own_we;

  logic            owned;
  logic            wr_done;
  logic            eol_hit;
  logic            lim_hit;
  logic            to_hit;
  logic            rel_now;

  // Index (base + off) modulo NUM, for off in [0, NUM)
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM) sum = sum - NUM;
    return IW'(sum);
  endfunction

  assign req      = bus.m_cyc_i & bus.m_stb_i;
  assign owned    = (state == OWNED);

  assign own_dat  = bus.m_dat_i[owner*Dw +: Dw];
  assign own_sel  = bus.m_sel_i[owner*SELw +: SELw];
  assign own_addr = bus.m_addr_i[owner*S_Aw +: S_Aw];
  assign own_cti  = bus.m_cti_i[owner*TAGw +: TAGw];
  assign own_stb  = bus.m_stb_i[owner];
  assign own_cyc  = bus.m_cyc_i[owner];
  assign own_we   = bus.m_we_i[owner];

  // Release only on an acked write or when the owner has no cycle open,
  // so an in-flight access is never cut.
  assign wr_done  = owned & bus.u_ack_i & own_stb & own_cyc & own_we;
  assign eol_hit  = wr_done & (own_dat[7:0] == EOL_CHAR);
  assign lim_hit  = wr_done & (char_cnt == CW'(MAX_CHARS - 1));
  assign to_hit   = owned & ~own_cyc & (idle_cnt == TW'(LOCK_TIMEOUT));
  assign rel_now  = eol_hit | lim_hit | to_hit;

  assign bus.grant_o = grant;

  // Round-robin pick: lowest offset from rr_ptr wins, so scan downward
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (req[wrap_idx(rr_ptr, i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(rr_ptr, i);
      end
    end
  end

  // Route the owner to the UART and the UART response back to the owner only
  always_comb begin
    bus.u_dat_o  = '0;
    bus.u_sel_o  = '0;
    bus.u_addr_o = '0;
    bus.u_cti_o  = '0;
    bus.u_stb_o  = 1'b0;
    bus.u_cyc_o  = 1'b0;
    bus.u_we_o   = 1'b0;
    bus.m_dat_o  = '0;
    bus.m_ack_o  = '0;
    if (owned) begin
      bus.u_dat_o  = own_dat;
      bus.u_sel_o  = own_sel;
      bus.u_addr_o = own_addr;
      bus.u_cti_o  = own_cti;
      bus.u_stb_o  = own_stb & own_cyc;
      bus.u_cyc_o  = own_cyc;
      bus.u_we_o   = own_we;
      bus.m_dat_o  = bus.u_dat_i;
      if (bus.u_ack_i && own_stb) bus.m_ack_o = grant;
    end
  end

  // Grant FSM with message counters; IDLE always lasts a cycle between owners
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      char_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= OWNED;
            owner    <= pick_idx;
            grant    <= NUM'(1) << pick_idx;
            char_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        OWNED: begin
          if (rel_now) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= wrap_idx(owner, 1);
            char_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            if (wr_done && char_cnt != CW'(MAX_CHARS)) char_cnt <= char_cnt + 1'b1;
            if (own_cyc) idle_cnt <= '0;
            else if (idle_cnt != TW'(LOCK_TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_uart_arbiter.sv
// Bench for sim_uart_arbiter: table of single-master accesses plus
// hand-written contention, char-limit, timeout and mid-message reset runs.
// A byte scoreboard receives the expected UART write order.
module tb_sim_uart_arbiter;

  localparam int NUM = 4;
  localparam int Dw = 32;
  localparam int S_Aw = 7;
  localparam int TAGw = 3;
  localparam int SELw = 4;
  localparam int LOCK_TIMEOUT = 10;
  localparam int MAX_CHARS = 4;
  localparam logic [Dw-1:0] RD_BASE = 32'h1234_5600;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  sim_uart_arbiter_if #(.NUM(NUM), .Dw(Dw), .S_Aw(S_Aw), .TAGw(TAGw), .SELw(SELw)) bus ();

  sim_uart_arbiter #(
    .NUM(NUM), .Dw(Dw), .S_Aw(S_Aw), .TAGw(TAGw), .SELw(SELw),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_CHARS(MAX_CHARS), .EOL_CHAR(8'h0A)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // UART model: ack the cycle after a strobe, one cycle wide
  logic ack_r;
  always @(posedge clk or negedge reset) begin
    if (!reset) ack_r <= 1'b0;
    else        ack_r <= bus.u_stb_o & ~ack_r;
  end
  assign bus.u_ack_i = ack_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard of expected UART writes: {master, byte}
  typedef struct { int mst; logic [7:0] b; } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  task automatic push(input int k, input logic [7:0] b);
    exp_t e;
    e.mst = k;
    e.b = b;
    sb.push_back(e);
  endtask

  // Each completed UART write is popped and compared in order
  always @(negedge clk) begin
    if (reset && bus.u_ack_i && bus.u_stb_o && bus.u_we_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%h required=none", bus.u_dat_o[7:0]);
      end else begin
        sb_e = sb.pop_front();
        chk("sb_byte", {24'h0, bus.u_dat_o[7:0]}, {24'h0, sb_e.b});
        chk("sb_owner", {28'h0, bus.grant_o}, 32'(1) << sb_e.mst);
      end
    end
  end

  // One wishbone access by master k; returns one cycle after the ack edge
  task automatic wb_access(input int k, input logic we, input logic [7:0] d,
                           input bit first, input logic [3:0] own);
    bit got;
    got = 1'b0;
    bus.m_dat_i[k*Dw +: Dw]     = {24'h0, d};
    bus.m_sel_i[k*SELw +: SELw] = '1;
    bus.m_addr_i[k*S_Aw +: S_Aw] = we ? 7'h00 : 7'h01;
    bus.m_cti_i[k*TAGw +: TAGw] = '0;
    bus.m_we_i[k]  = we;
    bus.m_cyc_i[k] = 1'b1;
    bus.m_stb_i[k] = 1'b1;
    if (!we) bus.u_dat_i = RD_BASE | Dw'(d);
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (first && n == 0) chk("arb_idle_cycle", {28'h0, bus.grant_o}, 32'h0);
      if (first && n == 1) chk("arb_latency", {28'h0, bus.grant_o}, {28'h0, own});
      if (bus.m_ack_o[k]) begin
        got = 1'b1;
        chk("ack_owner_only", {28'h0, bus.m_ack_o}, {28'h0, own});
        if (!we) chk("read_data", bus.m_dat_o, RD_BASE | Dw'(d));
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout mst=%0d actual=no_ack required=ack", k);
    end
    @(posedge clk);
    #1;
    bus.m_stb_i[k] = 1'b0;
  endtask

  // Write n bytes (LSB first) as one message, then close the cycle
  task automatic send_bytes(input int k, input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) wb_access(k, 1'b1, bytes[8*i +: 8], 1'b0, 4'(1 << k));
    bus.m_cyc_i[k] = 1'b0;
  endtask

  typedef struct {
    int         mst;
    logic       we;
    logic [7:0] dat;
    bit         first;
    bit         last;
    logic [3:0] own;
    logic [3:0] after;
  } vec_t;
  vec_t tbl[10];

  bit m0_done;
  bit m1_seen;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // "Hi\n" from master 2, then reads and writes from master 1
    tbl[0] = '{2, 1'b1, 8'h48, 1'b1, 1'b0, 4'b0100, 4'b0100};
    tbl[1] = '{2, 1'b1, 8'h69, 1'b0, 1'b0, 4'b0100, 4'b0100};
    tbl[2] = '{2, 1'b1, 8'h0A, 1'b0, 1'b1, 4'b0100, 4'b0000};
    tbl[3] = '{1, 1'b0, 8'hA5, 1'b1, 1'b0, 4'b0010, 4'b0010};
    tbl[4] = '{1, 1'b0, 8'h5A, 1'b0, 1'b0, 4'b0010, 4'b0010};
    tbl[5] = '{1, 1'b0, 8'h0A, 1'b0, 1'b0, 4'b0010, 4'b0010};
    tbl[6] = '{1, 1'b1, 8'h31, 1'b0, 1'b0, 4'b0010, 4'b0010};
    tbl[7] = '{1, 1'b1, 8'h32, 1'b0, 1'b0, 4'b0010, 4'b0010};
    tbl[8] = '{1, 1'b1, 8'h33, 1'b0, 1'b0, 4'b0010, 4'b0010};
    tbl[9] = '{1, 1'b1, 8'h0A, 1'b0, 1'b1, 4'b0010, 4'b0000};

    // Reset state with every master requesting
    bus.m_dat_i = '1;
    bus.m_sel_i = '1;
    bus.m_addr_i = '1;
    bus.m_cti_i = '1;
    bus.m_stb_i = '1;
    bus.m_cyc_i = '1;
    bus.m_we_i = '1;
    bus.u_dat_i = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", {28'h0, bus.grant_o}, 32'h0);
    chk("rst_u_stb", {31'h0, bus.u_stb_o}, 32'h0);
    chk("rst_u_cyc", {31'h0, bus.u_cyc_o}, 32'h0);
    chk("rst_u_dat", bus.u_dat_o, 32'h0);
    chk("rst_m_ack", {28'h0, bus.m_ack_o}, 32'h0);
    chk("rst_m_dat", bus.m_dat_o, 32'h0);
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_addr_i = '0;
    bus.m_cti_i = '0;
    bus.m_stb_i = '0;
    bus.m_cyc_i = '0;
    bus.m_we_i = '0;
    bus.u_dat_i = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Table: single-master messages
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) push(tbl[i].mst, tbl[i].dat);
      wb_access(tbl[i].mst, tbl[i].we, tbl[i].dat, tbl[i].first, tbl[i].own);
      if (tbl[i].last) bus.m_cyc_i[tbl[i].mst] = 1'b0;
      @(negedge clk);
      chk("grant_after", {28'h0, bus.grant_o}, {28'h0, tbl[i].after});
      @(posedge clk);
      #1;
    end

    // Contention: masters 0 and 1 send "AB\n" together from rr_ptr=0
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    push(0, 8'h41); push(0, 8'h42); push(0, 8'h0A);
    push(1, 8'h41); push(1, 8'h42); push(1, 8'h0A);
    m0_done = 1'b0;
    m1_seen = 1'b0;
    fork
      begin
        send_bytes(0, 64'h0A4241, 3);
        m0_done = 1'b1;
        @(negedge clk);
        chk("t2_idle_gap", {28'h0, bus.grant_o}, 32'h0);
        @(negedge clk);
        chk("t2_next_grant", {28'h0, bus.grant_o}, 32'h2);
      end
      send_bytes(1, 64'h0A4241, 3);
      begin
        for (int n = 0; n < 200 && !m1_seen; n++) begin
          @(negedge clk);
          if (bus.m_ack_o[1]) m1_seen = 1'b1;
        end
        chk("t2_m1_waits", {31'h0, m0_done}, 32'h1);
      end
    join

    // Char limit: master 3 sends 6 bytes without EOL while master 0 waits
    push(3, 8'h61); push(3, 8'h62); push(3, 8'h63); push(3, 8'h64);
    push(0, 8'h51); push(0, 8'h0A);
    push(3, 8'h65); push(3, 8'h66);
    fork
      send_bytes(3, 64'h666564636261, 6);
      send_bytes(0, 64'h0A51, 2);
    join
    for (int n = 0; n < 40 && bus.grant_o != 4'b0000; n++) @(negedge clk);
    chk("t3_idle_release", {28'h0, bus.grant_o}, 32'h0);
    @(posedge clk);
    #1;

    // Timeout: master 1 writes 'x' and goes quiet, master 2 waits
    push(1, 8'h78);
    push(2, 8'h0A);
    send_bytes(1, 64'h78, 1);
    fork
      begin
        for (int i = 0; i <= 12; i++) begin
          @(negedge clk);
          if (i == 10) chk("t4_held", {28'h0, bus.grant_o}, 32'h2);
          if (i == 11) chk("t4_release", {28'h0, bus.grant_o}, 32'h0);
          if (i == 12) chk("t4_next_grant", {28'h0, bus.grant_o}, 32'h4);
        end
      end
      send_bytes(2, 64'h0A, 1);
    join

    // Reset in the middle of an owned write
    bus.m_dat_i[0 +: Dw] = 32'h55;
    bus.m_we_i[0] = 1'b1;
    bus.m_cyc_i[0] = 1'b1;
    bus.m_stb_i[0] = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_owned", {28'h0, bus.grant_o}, 32'h1);
    chk("t6_stb_on", {31'h0, bus.u_stb_o}, 32'h1);
    reset = 1'b0;
    #1;
    chk("t6_grant_clr", {28'h0, bus.grant_o}, 32'h0);
    chk("t6_stb_clr", {31'h0, bus.u_stb_o}, 32'h0);
    chk("t6_cyc_clr", {31'h0, bus.u_cyc_o}, 32'h0);
    chk("t6_ack_clr", {28'h0, bus.m_ack_o}, 32'h0);
    bus.m_cyc_i[0] = 1'b0;
    bus.m_stb_i[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push(1, 8'h0A);
    push(3, 8'h0A);
    fork
      send_bytes(1, 64'h0A, 1);
      send_bytes(3, 64'h0A, 1);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t6_rr_restart", {28'h0, bus.grant_o}, 32'h2);
      end
    join

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
